// File: rtl/cache_line_adapter.sv
// Adapts whole-line cache fill/writeback requests into a sequence of 32-bit
// word accesses to main memory, assembling fill words back into a line.
module cache_line_adapter #(
    parameter int s_offset = 5,
    parameter int s_words  = 2 ** (s_offset - 2),
    parameter int s_line   = 8 * (2 ** s_offset)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              line_read_req,
    input  logic              line_write_req,
    input  logic [31:0]       line_addr,
    input  logic [s_line-1:0] line_wdata,
    output logic [s_line-1:0] line_rdata,
    output logic              line_ready,
    output logic              busy,
    output logic              mem_req,
    output logic              mem_we,
    output logic [31:0]       mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack
);

    localparam int CntW = (s_words > 1) ? $clog2(s_words) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(s_words - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state_r;
    state_t            stateNext_s;
    logic [CntW-1:0]   cnt_r;
    logic [CntW-1:0]   cntNext_s;
    logic [31:0]       base_r;
    logic [31:0]       baseNext_s;
    logic [s_line-1:0] wbuf_r;
    logic [s_line-1:0] wbufNext_s;
    logic [s_line-1:0] rdataNext_s;
    logic              reqNext_s;
    logic              weNext_s;
    logic [31:0]       addrNext_s;
    logic [31:0]       wdataNext_s;

    function automatic logic [31:0] wordAt(input logic [s_line-1:0] line,
                                           input logic [CntW-1:0]   idx);
        return line[32*int'(idx) +: 32];
    endfunction

    // Base is line-aligned, so adding the word offset never carries out of the line.
    function automatic logic [31:0] wordAddr(input logic [31:0]     base,
                                             input logic [CntW-1:0] idx);
        return base + (32'(idx) * 32'd4);
    endfunction

    // Next-state, word counter, latched request and fill-line update.
    always_comb begin
        stateNext_s = state_r;
        cntNext_s   = cnt_r;
        baseNext_s  = base_r;
        wbufNext_s  = wbuf_r;
        rdataNext_s = line_rdata;
        case (state_r)
            IDLE: begin
                if (line_write_req) begin
                    baseNext_s  = {line_addr[31:s_offset], {s_offset{1'b0}}};
                    wbufNext_s  = line_wdata;
                    cntNext_s   = {CntW{1'b0}};
                    stateNext_s = WRITE;
                end else if (line_read_req) begin
                    baseNext_s  = {line_addr[31:s_offset], {s_offset{1'b0}}};
                    cntNext_s   = {CntW{1'b0}};
                    stateNext_s = READ;
                end else begin
                    stateNext_s = IDLE;
                end
            end
            READ, WRITE: begin
                if (mem_ack) begin
                    if (state_r == READ) begin
                        rdataNext_s[32*int'(cnt_r) +: 32] = mem_rdata;
                    end else begin
                        rdataNext_s = line_rdata;
                    end
                    if (cnt_r == LastCnt) begin
                        stateNext_s = DONE;
                    end else begin
                        cntNext_s = cnt_r + {{(CntW-1){1'b0}}, 1'b1};
                    end
                end else begin
                    stateNext_s = state_r;
                end
            end
            DONE: begin
                stateNext_s = IDLE;
            end
            default: begin
                stateNext_s = IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so they can be registered without adding latency.
    always_comb begin
        reqNext_s   = (stateNext_s == READ) || (stateNext_s == WRITE);
        weNext_s    = (stateNext_s == WRITE);
        addrNext_s  = reqNext_s ? wordAddr(baseNext_s, cntNext_s) : 32'h0000_0000;
        wdataNext_s = weNext_s ? wordAt(wbufNext_s, cntNext_s) : 32'h0000_0000;
    end

    // State and registered outputs; reset also discards any partially filled line.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            cnt_r      <= {CntW{1'b0}};
            base_r     <= 32'h0000_0000;
            wbuf_r     <= {s_line{1'b0}};
            line_rdata <= {s_line{1'b0}};
            line_ready <= 1'b0;
            busy       <= 1'b0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= 32'h0000_0000;
            mem_wdata  <= 32'h0000_0000;
        end else begin
            state_r    <= stateNext_s;
            cnt_r      <= cntNext_s;
            base_r     <= baseNext_s;
            wbuf_r     <= wbufNext_s;
            line_rdata <= rdataNext_s;
            line_ready <= (stateNext_s == DONE);
            busy       <= (stateNext_s != IDLE);
            mem_req    <= reqNext_s;
            mem_we     <= weNext_s;
            mem_addr   <= addrNext_s;
            mem_wdata  <= wdataNext_s;
        end
    end

endmodule

// File: tb/tb_cache_line_adapter.sv
// Randomized and directed bench for cache_line_adapter against a transaction-level
// reference model; outputs are compared on every falling edge.
module tb_cache_line_adapter;

    localparam int NW = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         line_read_req;
    logic         line_write_req;
    logic [31:0]  line_addr;
    logic [255:0] line_wdata;
    logic [255:0] line_rdata;
    logic         line_ready;
    logic         busy;
    logic         mem_req;
    logic         mem_we;
    logic [31:0]  mem_addr;
    logic [31:0]  mem_wdata;
    logic [31:0]  mem_rdata;
    logic         mem_ack;
    logic [31:0]  memKey;

    always #5 clk = ~clk;

    cache_line_adapter dut (
        .clk            (clk),
        .rst            (rst),
        .line_read_req  (line_read_req),
        .line_write_req (line_write_req),
        .line_addr      (line_addr),
        .line_wdata     (line_wdata),
        .line_rdata     (line_rdata),
        .line_ready     (line_ready),
        .busy           (busy),
        .mem_req        (mem_req),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata),
        .mem_ack        (mem_ack)
    );

    // Memory contents: each word is its own address scrambled by a key.
    assign mem_rdata = mem_addr ^ memKey;

    int vectors = 0;
    int errors  = 0;
    int ackMode = 3;
    int ackPhase = 0;
    bit checkEn = 1'b0;

    int          readyPulses, busyCycles, writeCount, readCount;
    logic [31:0] maxAddr, minAddr, lastWaddr, lastWdata;

    // Reference model: operation in flight (0 none, 1 fill, 2 writeback), word index, done pulse.
    int           mOp   = 0;
    int           mIdx  = 0;
    bit           mDone = 1'b0;
    logic [31:0]  mBase = 32'h0;
    logic [255:0] mW    = 256'h0;
    logic [255:0] mR    = 256'h0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            mOp = 0; mIdx = 0; mDone = 1'b0; mBase = 32'h0; mR = 256'h0;
        end else if (mDone) begin
            mDone = 1'b0;
        end else if (mOp != 0) begin
            if (mem_ack) begin
                if (mOp == 1) mR[32*mIdx +: 32] = (mBase + 32'(4*mIdx)) ^ memKey;
                if (mIdx == NW-1) begin
                    mOp = 0; mDone = 1'b1;
                end else begin
                    mIdx++;
                end
            end
        end else if (line_write_req) begin
            mOp = 2; mIdx = 0; mBase = line_addr & 32'hFFFF_FFE0; mW = line_wdata;
        end else if (line_read_req) begin
            mOp = 1; mIdx = 0; mBase = line_addr & 32'hFFFF_FFE0;
        end
    end

    // Event monitors on DUT outputs, sampled at the clock edge that consumes them.
    always @(posedge clk) begin
        if (line_ready) readyPulses++;
        if (busy) busyCycles++;
        if (mem_req && mem_ack) begin
            if (mem_we) begin
                writeCount++;
                lastWaddr = mem_addr;
                lastWdata = mem_wdata;
            end else begin
                readCount++;
            end
            if (mem_addr > maxAddr) maxAddr = mem_addr;
            if (mem_addr < minAddr) minAddr = mem_addr;
        end
    end

    always @(negedge clk) begin
        if (checkEn) begin
            check("mem_req",    mem_req,    mOp != 0);
            check("mem_we",     mem_we,     mOp == 2);
            check("mem_addr",   mem_addr,   (mOp != 0) ? mBase + 32'(4*mIdx) : 32'h0);
            check("mem_wdata",  mem_wdata,  (mOp == 2) ? mW[32*mIdx +: 32] : 32'h0);
            check("busy",       busy,       (mOp != 0) || mDone);
            check("line_ready", line_ready, mDone);
            check("line_rdata", line_rdata, mR);
        end
    end

    task automatic resetMon();
        readyPulses = 0; busyCycles = 0; writeCount = 0; readCount = 0;
        maxAddr = 32'h0; minAddr = 32'hFFFF_FFFF; lastWaddr = 32'h0; lastWdata = 32'h0;
    endtask

    task automatic step();
        @(negedge clk);
        case (ackMode)
            0: mem_ack = 1'b1;
            1: begin ackPhase = (ackPhase + 1) % 3; mem_ack = (ackPhase == 0); end
            2: mem_ack = 1'($urandom_range(0, 1));
            default: mem_ack = 1'b0;
        endcase
    endtask

    task automatic issue(input bit rd, input bit wr, input logic [31:0] a, input logic [255:0] d);
        step();
        line_read_req = rd; line_write_req = wr; line_addr = a; line_wdata = d;
        step();
        line_read_req = 1'b0; line_write_req = 1'b0;
    endtask

    task automatic waitReady(input int bound, output int steps);
        steps = 0;
        while (!line_ready && steps < bound) begin
            step();
            steps++;
        end
        vectors++;
        if (!line_ready) begin
            errors++;
            $display("FAIL wait_ready: got timeout after %0d cycles expected line_ready", steps);
        end
    endtask

    initial begin
        int steps;
        logic [255:0] wline;
        logic [31:0]  key2;
        rst = 1'b1; line_read_req = 1'b0; line_write_req = 1'b0;
        line_addr = 32'h0; line_wdata = 256'h0; mem_ack = 1'b0; memKey = 32'h0;
        resetMon();
        @(posedge clk);
        checkEn = 1'b1;
        step(); step();
        check("reset_busy",  busy,       1'b0);
        check("reset_req",   mem_req,    1'b0);
        check("reset_rdata", line_rdata, 256'h0);
        rst = 1'b0;

        // Fill with ack tied high, memory word = its address.
        ackMode = 0; resetMon();
        issue(1'b1, 1'b0, 32'h0000_1234, 256'h0);
        waitReady(40, steps);
        check("fill_latency", steps + 1, 9);
        step(); step();
        check("fill_pulses", readyPulses, 1);
        check("fill_reads",  readCount,   8);
        check("fill_minaddr", minAddr,    32'h0000_1220);
        check("fill_maxaddr", maxAddr,    32'h0000_123C);
        check("fill_word0",  line_rdata[31:0],    32'h0000_1220);
        check("fill_word7",  line_rdata[255:224], 32'h0000_123C);

        // Writeback with ack every third cycle.
        for (int i = 0; i < NW; i++) wline[32*i +: 32] = 32'hA0A0_0000 + 32'(i);
        ackMode = 1; ackPhase = 0; resetMon();
        issue(1'b0, 1'b1, 32'h0000_0200, wline);
        waitReady(100, steps);
        step(); step();
        check("wb_writes",    writeCount, 8);
        check("wb_reads",     readCount,  0);
        check("wb_lastaddr",  lastWaddr,  32'h0000_021C);
        check("wb_lastdata",  lastWdata,  32'hA0A0_0007);
        check("wb_rdata_kept", line_rdata[255:224], 32'h0000_123C);

        // Simultaneous read and write at 0x40.
        ackMode = 0; resetMon();
        issue(1'b1, 1'b1, 32'h0000_0040, {8{32'h5A5A_0F0F}});
        waitReady(40, steps);
        step(); step(); step();
        check("both_busy",   busyCycles, 9);
        check("both_reads",  readCount,  0);
        check("both_writes", writeCount, 8);

        // Read request at 0x80 during a fill of 0x00 is ignored.
        ackMode = 2; memKey = 32'h1357_9BDF; resetMon();
        issue(1'b1, 1'b0, 32'h0000_0000, 256'h0);
        issue(1'b1, 1'b0, 32'h0000_0080, 256'h0);
        waitReady(200, steps);
        step(); step(); step();
        check("ovl_maxaddr", maxAddr,     32'h0000_001C);
        check("ovl_reads",   readCount,   8);
        check("ovl_pulses",  readyPulses, 1);

        // Reset after the third ack aborts the fill.
        ackMode = 0; memKey = 32'h0; resetMon();
        issue(1'b1, 1'b0, 32'h0000_0300, 256'h0);
        steps = 0;
        while (readCount < 3 && steps < 20) begin step(); steps++; end
        check("abort_acks", readCount, 3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort_req",   mem_req,    1'b0);
        check("abort_busy",  busy,       1'b0);
        check("abort_rdata", line_rdata, 256'h0);
        step(); step(); step();
        check("abort_pulses", readyPulses, 0);
        key2 = $urandom; memKey = key2; resetMon();
        issue(1'b1, 1'b0, 32'h0000_0300, 256'h0);
        waitReady(40, steps);
        step(); step();
        check("refill_pulses", readyPulses, 1);
        check("refill_word0",  line_rdata[31:0],    32'h0000_0300 ^ key2);
        check("refill_word7",  line_rdata[255:224], 32'h0000_031C ^ key2);

        // Spurious acks while idle leave the line untouched.
        ackMode = 0; resetMon();
        for (int i = 0; i < 6; i++) step();
        check("idle_ack_rdata", line_rdata[31:0], 32'h0000_0300 ^ key2);
        check("idle_ack_reads", readCount, 0);

        // Randomized traffic, including occasional resets.
        ackMode = 2;
        for (int i = 0; i < 600; i++) begin
            step();
            if (i % 150 == 0) memKey = $urandom;
            rst            = ($urandom_range(0, 99) == 0);
            line_read_req  = ($urandom_range(0, 5) == 0);
            line_write_req = ($urandom_range(0, 5) == 0);
            line_addr      = $urandom;
            line_wdata     = {$urandom, $urandom, $urandom, $urandom,
                              $urandom, $urandom, $urandom, $urandom};
        end
        rst = 1'b0; line_read_req = 1'b0; line_write_req = 1'b0;
        for (int i = 0; i < 40; i++) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
